// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared state/owner encodings, default burst length and line-base helper
package mem_arbiter_pkg;
  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_BUSY_I = 2'd1,
    ARB_BUSY_D = 2'd2,
    ARB_DONE   = 2'd3
  } arb_state_t;

  typedef enum logic {
    OWNER_I = 1'b0,
    OWNER_D = 1'b1
  } owner_t;

  localparam int DEF_BURST_LEN = 4;

  function automatic logic [63:0] line_base(input logic [63:0] addr, input int line_bytes);
    return addr & ~(64'(line_bytes) - 64'd1);
  endfunction
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: combinational 2-way round-robin pick between I and D
//   i_req, d_req : requests
//   last_owner   : requester granted most recently (held by the caller)
//   grant        : some request is present
//   owner        : winning requester
module rr_arb2
  import mem_arbiter_pkg::*;
(
  input  logic   i_req,
  input  logic   d_req,
  input  owner_t last_owner,
  output logic   grant,
  output owner_t owner
);
  assign grant = i_req | d_req;
  // On a tie the requester that was not served last wins.
  assign owner = (i_req && d_req) ? ((last_owner == OWNER_I) ? OWNER_D : OWNER_I)
                                  : (d_req ? OWNER_D : OWNER_I);
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between I-cache refills and D-cache refills/write-backs
//   clk_i, rst_n_i          : clock, async active-low reset
//   i_req_i/i_addr_i        : I line-read request; i_rvalid_o/i_rdata_o/i_done_o/i_busy_o back
//   d_req_i/d_we_i/d_addr_i : D request; d_wdata_i supplies beat d_beat_o; d_rvalid_o/d_rdata_o/d_done_o/d_busy_o back
//   mem_*                   : one beat per cycle; a beat completes when mem_req_o && mem_ready_i
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int DATA_W    = 64,
  parameter int BURST_LEN = DEF_BURST_LEN,
  localparam int BEAT_W   = $clog2(BURST_LEN)
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              i_req_i,
  input  logic [63:0]       i_addr_i,
  output logic              i_rvalid_o,
  output logic [DATA_W-1:0] i_rdata_o,
  output logic              i_done_o,
  output logic              i_busy_o,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [63:0]       d_addr_i,
  input  logic [DATA_W-1:0] d_wdata_i,
  output logic [BEAT_W-1:0] d_beat_o,
  output logic              d_rvalid_o,
  output logic [DATA_W-1:0] d_rdata_o,
  output logic              d_done_o,
  output logic              d_busy_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [63:0]       mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_ready_i,
  input  logic [DATA_W-1:0] mem_rdata_i
);
  localparam int WORD_B = DATA_W / 8;
  localparam int OFF_W  = $clog2(WORD_B);

  arb_state_t        state, state_nxt;
  owner_t            owner, last_owner, pick;
  logic              grant, we, busy, beat_ok, last_beat, win;
  logic [63:0]       base;
  logic [BEAT_W-1:0] cnt;

  rr_arb2 u_rr (
    .i_req      (i_req_i),
    .d_req      (d_req_i),
    .last_owner (last_owner),
    .grant      (grant),
    .owner      (pick)
  );

  assign busy      = (state == ARB_BUSY_I) || (state == ARB_BUSY_D);
  assign beat_ok   = busy && mem_ready_i;
  assign last_beat = cnt == BEAT_W'(BURST_LEN - 1);
  assign win       = (state == ARB_IDLE) && grant;
  assign d_beat_o  = cnt;
  assign i_busy_o  = i_req_i | (owner == OWNER_I && state != ARB_IDLE);
  assign d_busy_o  = d_req_i | (owner == OWNER_D && state != ARB_IDLE);

  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) state <= ARB_IDLE;
    else          state <= state_nxt;

  always_comb begin
    state_nxt = state;
    if (win) state_nxt = (pick == OWNER_D) ? ARB_BUSY_D : ARB_BUSY_I;
    if (beat_ok && last_beat) state_nxt = ARB_DONE;
    if (state == ARB_DONE) state_nxt = ARB_IDLE;
    mem_req_o   = busy;
    mem_we_o    = busy && we;
    // base is line-aligned, so the beat offset never carries out of the line.
    mem_addr_o  = busy ? base + (64'(cnt) << OFF_W) : '0;
    mem_wdata_o = (busy && we) ? d_wdata_i : '0;
    i_done_o    = (state == ARB_DONE) && (owner == OWNER_I);
    d_done_o    = (state == ARB_DONE) && (owner == OWNER_D);
  end

  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      owner      <= OWNER_I;
      last_owner <= OWNER_I;
      we         <= 1'b0;
      base       <= '0;
      cnt        <= '0;
      i_rvalid_o <= 1'b0;
      d_rvalid_o <= 1'b0;
      i_rdata_o  <= '0;
      d_rdata_o  <= '0;
    end else begin
      i_rvalid_o <= beat_ok && !we && owner == OWNER_I;
      d_rvalid_o <= beat_ok && !we && owner == OWNER_D;
      if (beat_ok && !we && owner == OWNER_I) i_rdata_o <= mem_rdata_i;
      if (beat_ok && !we && owner == OWNER_D) d_rdata_o <= mem_rdata_i;
      if (win) begin
        owner <= pick;
        we    <= (pick == OWNER_D) && d_we_i;
        base  <= line_base((pick == OWNER_D) ? d_addr_i : i_addr_i, BURST_LEN * WORD_B);
        cnt   <= '0;
      end
      // Counter wraps to 0 on the last beat, so it reads 0 in DONE and IDLE.
      if (beat_ok) cnt <= cnt + BEAT_W'(1);
      if (beat_ok && last_beat) last_owner <= owner;
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized self-checking bench with a transaction-level reference model
module tb_mem_arbiter;
  localparam int DW = 64;
  localparam int BL = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_req, d_req, d_we, mem_ready;
  logic [63:0]   i_addr, d_addr;
  logic [DW-1:0] d_wdata, mem_rdata;
  logic          i_rvalid, i_done, i_busy, d_rvalid, d_done, d_busy;
  logic          mem_req, mem_we;
  logic [DW-1:0] i_rdata, d_rdata, mem_wdata;
  logic [63:0]   mem_addr;
  logic [1:0]    d_beat;

  int checks = 0;
  int errors = 0;
  bit last_d;

  always #5 clk = ~clk;

  mem_arbiter #(.DATA_W(DW), .BURST_LEN(BL)) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .i_req_i     (i_req),
    .i_addr_i    (i_addr),
    .i_rvalid_o  (i_rvalid),
    .i_rdata_o   (i_rdata),
    .i_done_o    (i_done),
    .i_busy_o    (i_busy),
    .d_req_i     (d_req),
    .d_we_i      (d_we),
    .d_addr_i    (d_addr),
    .d_wdata_i   (d_wdata),
    .d_beat_o    (d_beat),
    .d_rvalid_o  (d_rvalid),
    .d_rdata_o   (d_rdata),
    .d_done_o    (d_done),
    .d_busy_o    (d_busy),
    .mem_req_o   (mem_req),
    .mem_we_o    (mem_we),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .mem_ready_i (mem_ready),
    .mem_rdata_i (mem_rdata)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_req"}, 64'(mem_req), 64'(0));
    check({tag, "_we"}, 64'(mem_we), 64'(0));
    check({tag, "_addr"}, mem_addr, 64'(0));
    check({tag, "_wdata"}, mem_wdata, 64'(0));
    check({tag, "_idone"}, 64'(i_done), 64'(0));
    check({tag, "_ddone"}, 64'(d_done), 64'(0));
    check({tag, "_beat"}, 64'(d_beat), 64'(0));
  endtask

  task automatic do_reset();
    i_req = 1'b0;
    d_req = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    last_d = 1'b0;
    @(posedge clk); #1;
  endtask

  // Serves every pending request. Entered and left at posedge+1 of an IDLE cycle.
  // sb/sl: hold ready low for sl cycles on beat sb; rnd: random stalls and req traffic;
  // rereq: the first winner requests again right after its DONE.
  task automatic serve(input int sb, input int sl, input bit rnd, input bit rereq);
    bit w, we, pv, first;
    logic [63:0] base, pdata;
    int k, st, tot;
    first = 1'b1;
    while (i_req || d_req) begin
      mem_ready = 1'b1;
      #1;
      check_quiet("idle");
      check("idle_irv", 64'(i_rvalid), 64'(0));
      check("idle_drv", 64'(d_rvalid), 64'(0));
      check("idle_ibusy", 64'(i_busy), 64'(i_req));
      check("idle_dbusy", 64'(d_busy), 64'(d_req));
      w = (i_req && d_req) ? !last_d : d_req;
      base = (w ? d_addr : i_addr) & ~64'(BL * DW / 8 - 1);
      we = w && d_we;
      pv = 1'b0;
      pdata = '0;
      k = 0;
      st = 0;
      tot = 0;
      while (k < BL) begin
        @(posedge clk); #1;
        check("beat_irv", 64'(i_rvalid), 64'(pv && !w));
        check("beat_drv", 64'(d_rvalid), 64'(pv && w));
        if (pv) check("beat_rdata", w ? d_rdata : i_rdata, pdata);
        d_wdata = {$urandom, $urandom};
        mem_rdata = {$urandom, $urandom};
        mem_ready = (k == sb && st < sl) ? 1'b0 : (rnd && tot < 12) ? ($urandom_range(0, 3) != 0) : 1'b1;
        if (rnd && $urandom_range(0, 7) == 0) begin
          if (w) d_req = 1'b0;
          else   i_req = 1'b0;
        end
        if (rnd && $urandom_range(0, 7) == 0) begin
          if (w && !i_req) begin
            i_req = 1'b1;
            i_addr = {$urandom, $urandom};
          end
          if (!w && !d_req) begin
            d_req = 1'b1;
            d_we = 1'($urandom);
            d_addr = {$urandom, $urandom};
          end
        end
        #1;
        check("beat_req", 64'(mem_req), 64'(1));
        check("beat_addr", mem_addr, base + 64'(k * DW / 8));
        check("beat_we", 64'(mem_we), 64'(we));
        check("beat_wdata", mem_wdata, we ? d_wdata : 64'(0));
        check("beat_idx", 64'(d_beat), 64'(k));
        check("beat_idone", 64'(i_done), 64'(0));
        check("beat_ddone", 64'(d_done), 64'(0));
        check("beat_ibusy", 64'(i_busy), 64'(i_req || !w));
        check("beat_dbusy", 64'(d_busy), 64'(d_req || w));
        pv = mem_ready && !we;
        pdata = mem_rdata;
        if (mem_ready) k++;
        else begin
          tot++;
          if (k == sb) st++;
        end
      end
      @(posedge clk); #1;
      mem_ready = 1'($urandom);
      #1;
      check("done_i", 64'(i_done), 64'(!w));
      check("done_d", 64'(d_done), 64'(w));
      check("done_req", 64'(mem_req), 64'(0));
      check("done_beat", 64'(d_beat), 64'(0));
      check("done_irv", 64'(i_rvalid), 64'(pv && !w));
      check("done_drv", 64'(d_rvalid), 64'(pv && w));
      if (pv) check("done_rdata", w ? d_rdata : i_rdata, pdata);
      check("done_ibusy", 64'(i_busy), 64'(i_req || !w));
      check("done_dbusy", 64'(d_busy), 64'(d_req || w));
      last_d = w;
      @(posedge clk); #1;
      if ((rereq && first) || (rnd && $urandom_range(0, 3) == 0)) begin
        if (w) begin
          d_req = 1'b1;
          d_addr = rereq ? d_addr : {$urandom, $urandom};
        end else begin
          i_req = 1'b1;
          i_addr = {$urandom, $urandom};
        end
      end else if (w) d_req = 1'b0;
      else i_req = 1'b0;
      first = 1'b0;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    i_req = 1'b0;
    d_req = 1'b0;
    d_we = 1'b0;
    i_addr = '0;
    d_addr = '0;
    d_wdata = {$urandom, $urandom};
    mem_ready = 1'b1;
    mem_rdata = {$urandom, $urandom};
    repeat (2) @(posedge clk);
    #1;
    check_quiet("rst");
    check("rst_irv", 64'(i_rvalid), 64'(0));
    check("rst_drv", 64'(d_rvalid), 64'(0));
    check("rst_irdata", i_rdata, 64'(0));
    check("rst_drdata", d_rdata, 64'(0));
    @(negedge clk) rst_n = 1'b1;
    last_d = 1'b0;
    @(posedge clk); #1;

    i_req = 1'b1;
    i_addr = 64'h1014;
    serve(-1, 0, 1'b0, 1'b0);

    do_reset();
    i_req = 1'b1;
    d_req = 1'b1;
    d_we = 1'b0;
    i_addr = {$urandom, $urandom};
    d_addr = {$urandom, $urandom};
    serve(-1, 0, 1'b0, 1'b1);

    d_req = 1'b1;
    d_we = 1'b1;
    d_addr = {$urandom, $urandom};
    serve(-1, 0, 1'b0, 1'b0);

    i_req = 1'b1;
    i_addr = {$urandom, $urandom};
    serve(2, 3, 1'b0, 1'b0);

    i_req = 1'b1;
    i_addr = {$urandom, $urandom};
    mem_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("mid_beat", 64'(d_beat), 64'(1));
    check("mid_irv", 64'(i_rvalid), 64'(1));
    rst_n = 1'b0;
    #1;
    check_quiet("arst");
    check("arst_irv", 64'(i_rvalid), 64'(0));
    check("arst_irdata", i_rdata, 64'(0));
    i_req = 1'b0;
    @(posedge clk); #1;
    check("arst_hold_idone", 64'(i_done), 64'(0));
    check("arst_hold_req", 64'(mem_req), 64'(0));
    @(negedge clk) rst_n = 1'b1;
    last_d = 1'b0;
    @(posedge clk); #1;
    i_req = 1'b1;
    serve(-1, 0, 1'b0, 1'b0);

    for (int n = 0; n < 150; n++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      i_req = 1'($urandom);
      d_req = 1'($urandom);
      if (!i_req && !d_req) i_req = 1'b1;
      d_we = 1'($urandom);
      i_addr = {$urandom, $urandom};
      d_addr = {$urandom, $urandom};
      serve(-1, 0, 1'b1, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
